// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car plant and its controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } car_state_t;

  // Command encoding {motor, direction} as issued by the controller.
  localparam logic [1:0] STOP       = 2'b00;
  localparam logic [1:0] UP_GOING   = 2'b11;
  localparam logic [1:0] DOWN_GOING = 2'b10;

  localparam int FLOOR_W = 5;

  // A move is legal unless it would leave the shaft.
  function automatic logic move_legal(input int floor, input logic dir, input int num_floors);
    return dir ? (floor < num_floors - 1) : (floor > 0);
  endfunction

endpackage

// File: rtl/car_down_counter.sv
// Loadable down counter that saturates at zero; used for travel and door timing.
module car_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/elevator_car_model.sv
// Elevator car/shaft plant: turns motor/direction commands into floor position,
// travel timing, door dwell and fault flag. Optional ELEVATOR_CAR_ESTOP_EN adds estop.
module elevator_car_model
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 5,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               motor,
  input  logic               direction,
`ifdef ELEVATOR_CAR_ESTOP_EN
  input  logic               estop,
`endif
  output logic [FLOOR_W-1:0] floor_cur,
  output logic               moving,
  output logic               at_floor,
  output logic               door_open,
  output logic               arrive,
  output logic               fault
);

  localparam int TRAV_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [TRAV_W-1:0] TRAV_LOAD = TRAV_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_CYCLES - 1);

  car_state_t         state_q, state_d;
  logic               dir_q, dir_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               arrive_q, arrive_d;
  logic               fault_q, fault_d;

  logic               trav_load, trav_dec, trav_zero;
  logic               door_load, door_dec, door_zero;
  logic [TRAV_W-1:0]  trav_count;
  logic [DOOR_W-1:0]  door_count;
  logic               estop_active;

`ifdef ELEVATOR_CAR_ESTOP_EN
  assign estop_active = estop;
`else
  assign estop_active = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    arrive_d  = 1'b0;
    fault_d   = fault_q;
    trav_load = 1'b0;
    trav_dec  = 1'b0;
    door_load = 1'b0;
    door_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (motor) begin
          if (move_legal(int'(floor_q), direction, NUM_FLOORS)) begin
            dir_d     = direction;
            trav_load = 1'b1;
            state_d   = MOVING;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      MOVING: begin
        if (trav_zero) begin
          floor_d  = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
          arrive_d = 1'b1;
          // Only a same-direction legal request rolls straight into the next span.
          if (motor && (direction == dir_q) && move_legal(int'(floor_d), dir_q, NUM_FLOORS)) begin
            trav_load = 1'b1;
          end else begin
            door_load = 1'b1;
            state_d   = DOOR;
          end
        end else begin
          trav_dec = 1'b1;
        end
      end
      DOOR: begin
        if (door_zero) begin
          state_d = IDLE;
        end else begin
          door_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Emergency stop freezes position and drops any in-progress span or dwell.
    if (estop_active) begin
      state_d   = IDLE;
      dir_d     = dir_q;
      floor_d   = floor_q;
      arrive_d  = 1'b0;
      fault_d   = fault_q;
      trav_load = 1'b0;
      trav_dec  = 1'b0;
      door_load = 1'b0;
      door_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      floor_q  <= '0;
      arrive_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      floor_q  <= floor_d;
      arrive_q <= arrive_d;
      fault_q  <= fault_d;
    end
  end

  car_down_counter #(.W(TRAV_W)) u_travel_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (trav_load),
    .load_val (TRAV_LOAD),
    .dec_en   (trav_dec),
    .count    (trav_count),
    .zero     (trav_zero)
  );

  car_down_counter #(.W(DOOR_W)) u_door_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (door_load),
    .load_val (DOOR_LOAD),
    .dec_en   (door_dec),
    .count    (door_count),
    .zero     (door_zero)
  );

  logic unused_counts;
  assign unused_counts = ^{trav_count, door_count};

  assign floor_cur = floor_q;
  assign moving    = (state_q == MOVING);
  assign at_floor  = (state_q != MOVING);
  assign door_open = (state_q == DOOR);
  assign arrive    = arrive_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_car_model.sv
// Randomized bench for elevator_car_model with a timestamp-based reference model.
module tb_elevator_car_model;
  import elevator_pkg::*;

  localparam int NF     = 5;
  localparam int TRAVEL = 8;
  localparam int DWELL  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       motor;
  logic       direction;
  logic       estop;
  logic [4:0] floor_cur;
  logic       moving, at_floor, door_open, arrive, fault;

  always #5 clk = ~clk;

  elevator_car_model #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TRAVEL),
    .DOOR_CYCLES   (DWELL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .motor     (motor),
    .direction (direction),
`ifdef ELEVATOR_CAR_ESTOP_EN
    .estop     (estop),
`endif
    .floor_cur (floor_cur),
    .moving    (moving),
    .at_floor  (at_floor),
    .door_open (door_open),
    .arrive    (arrive),
    .fault     (fault)
  );

  // Scoreboard queues: per-cycle status vector and floor reported on each arrival.
  logic [9:0] st_q[$];
  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 travelling, 2 door; events are absolute edge numbers.
  int   cyc = 0;
  int   m_floor = 0;
  int   m_mode = 0;
  logic m_dir = 1'b0;
  int   m_arrive_edge = 0;
  int   m_door_edge = 0;
  logic m_fault = 1'b0;
  logic m_arrive = 1'b0;

  function automatic logic can_go(input int f, input logic up);
    return up ? (f + 1 <= NF - 1) : (f - 1 >= 0);
  endfunction

  task automatic model_edge();
    cyc++;
    m_arrive = 1'b0;
    if (!rst) begin
      m_floor = 0; m_mode = 0; m_fault = 1'b0; m_dir = 1'b0;
`ifdef ELEVATOR_CAR_ESTOP_EN
    end else if (estop) begin
      m_mode = 0;
`endif
    end else if (m_mode == 0) begin
      if (motor) begin
        if (can_go(m_floor, direction)) begin
          m_mode = 1; m_dir = direction; m_arrive_edge = cyc + TRAVEL;
        end else begin
          m_fault = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      if (cyc == m_arrive_edge) begin
        m_floor  = m_dir ? m_floor + 1 : m_floor - 1;
        m_arrive = 1'b1;
        exp_q.push_back(m_floor[4:0]);
        if (motor && direction == m_dir && can_go(m_floor, m_dir)) begin
          m_arrive_edge = cyc + TRAVEL;
        end else begin
          m_mode = 2; m_door_edge = cyc + DWELL;
        end
      end
    end else begin
      if (cyc == m_door_edge) m_mode = 0;
    end
    st_q.push_back({m_floor[4:0], m_mode == 1, m_mode != 1, m_mode == 2, m_arrive, m_fault});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic drive(input logic [1:0] cmd, input int n);
    motor     = cmd[1];
    direction = cmd[0];
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  logic [9:0] mon_exp;
  logic [9:0] mon_act;
  logic [4:0] mon_floor;

  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      mon_exp = st_q.pop_front();
      mon_act = {floor_cur, moving, at_floor, door_open, arrive, fault};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL status @%0t: actual floor=%0d mv=%b af=%b door=%b arr=%b flt=%b, required floor=%0d mv=%b af=%b door=%b arr=%b flt=%b",
                 $time, mon_act[9:5], mon_act[4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                 mon_exp[9:5], mon_exp[4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
      end
    end
    if (arrive === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL arrive_unexpected @%0t: actual arrive=1 floor=%0d, required no arrival", $time, floor_cur);
      end else begin
        mon_floor = exp_q.pop_front();
        if (floor_cur !== mon_floor) begin
          errors++;
          $display("FAIL arrive_floor @%0t: actual %0d, required %0d", $time, floor_cur, mon_floor);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; motor = 1'b0; direction = 1'b0; estop = 1'b0;
    do_reset(2);

    // Single one-floor trip with door dwell.
    drive(UP_GOING, 1);
    drive(STOP, 20);
    // Held UP from 0 to top, then a fault at the top.
    do_reset(1);
    drive(UP_GOING, 40);
    drive(STOP, 10);
    drive(UP_GOING, 3);
    drive(STOP, 2);
    // DOWN at floor 0 is illegal.
    do_reset(1);
    drive(DOWN_GOING, 3);
    drive(STOP, 2);
    // Direction flip mid-span 2->3 stops at 3 then heads down on the held command.
    do_reset(1);
    drive(UP_GOING, 19);
    drive(DOWN_GOING, 30);
    drive(STOP, 6);
    // Reset during door dwell.
    do_reset(1);
    drive(UP_GOING, 24);
    drive(STOP, 2);
    do_reset(1);
    drive(STOP, 3);
`ifdef ELEVATOR_CAR_ESTOP_EN
    // Emergency stop mid-span 1->2, then release and hold until a new command.
    do_reset(1);
    drive(UP_GOING, 1);
    drive(STOP, 15);
    drive(UP_GOING, 1);
    drive(STOP, 3);
    estop = 1'b1;
    drive(STOP, 3);
    estop = 1'b0;
    drive(STOP, 12);
    drive(UP_GOING, 1);
    drive(STOP, 15);
`endif

    // Randomized command bursts with occasional resets.
    for (int b = 0; b < 120; b++) begin
      logic [1:0] cmd;
      int sel;
      sel = $urandom_range(0, 9);
      cmd = (sel < 3) ? STOP : ((sel < 6) ? DOWN_GOING : UP_GOING);
`ifdef ELEVATOR_CAR_ESTOP_EN
      estop = ($urandom_range(0, 19) == 0);
`endif
      if ($urandom_range(0, 24) == 0) begin
        do_reset($urandom_range(1, 2));
      end
      drive(cmd, $urandom_range(1, 22));
    end
    estop = 1'b0;
    drive(STOP, 3);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL arrive_missing: actual %0d pending arrivals, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
